serial_adder_seq: RTL and testbench

//   Bit-serial N-bit adder built around a single full-adder bit slice plus a carry flop.

---
 rtl/serial_adder_seq.sv | 125 ++++++++++++
 tb/tb_serial_adder_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus carry flop, LSB first.
// Optional subtract mode (extra `sub` input) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, done_q;

  logic [WIDTH-1:0]   load_b;
  logic               load_c;
  logic               fa_s, fa_c;

  // Operand B / carry-in as latched on an accepted start (inverted B for subtract).
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    load_b = sub ? ~b : b;
    load_c = sub ? 1'b1 : cin;
`else
    load_b = b;
    load_c = cin;
`endif
  end

  // Single full-adder bit slice on the current LSBs.
  always_comb begin
    fa_s = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    fa_c = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    count_d = count_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = load_b;
          carry_d = load_c;
          count_d = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      count_q <= count_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq (WIDTH=8); subtract tests only when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic [W:0]   sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push the expected {cout,sum}, present the operands for one accept edge.
  task automatic drive_start(input logic [W-1:0] ia, input logic [W-1:0] ib,
                             input logic icin, input logic isub);
    logic [W:0] e;
    if (isub) e = {1'b0, ia} + {1'b0, ~ib} + (W+1)'(1);
    else      e = {1'b0, ia} + {1'b0, ib} + (W+1)'(icin);
    sb_q.push_back(e);
    a = ia; b = ib; cin = icin;
`ifdef SERIAL_ADDER_SUB_EN
    sub = isub;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance at least one cycle, until done or the budget runs out.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (done !== 1'b1 && cyc < 4 * W);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
  endtask

  task automatic test_add;
    logic [W-1:0] ta[8];
    logic [W-1:0] tb[8];
    logic         tc[8];
    logic [W:0]   exp;
    int           cyc;
    ta[0] = 8'h5A; tb[0] = 8'h33; tc[0] = 1'b0;
    ta[1] = 8'hFF; tb[1] = 8'h01; tc[1] = 1'b0;
    ta[2] = 8'hFF; tb[2] = 8'hFF; tc[2] = 1'b1;
    ta[3] = 8'h00; tb[3] = 8'h00; tc[3] = 1'b1;
    for (int i = 4; i < 8; i++) begin
      ta[i] = W'($urandom); tb[i] = W'($urandom); tc[i] = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      drive_start(ta[i], tb[i], tc[i], 1'b0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy[%0d] got=%b exp=1", i, busy); end
      wait_done(cyc);
      n_checks++;
      if (done !== 1'b1 || cyc != W) begin
        n_fail++; $display("FAIL add_latency[%0d] done=%b cycles=%0d exp=%0d", i, done, cyc, W);
      end
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++; $display("FAIL add_sb_empty[%0d]", i);
      end else begin
        exp = sb_q.pop_front();
        if ({cout, sum} !== exp) begin
          n_fail++; $display("FAIL add_result[%0d] got=%b_%h exp=%b_%h", i, cout, sum, exp[W], exp[W-1:0]);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
          n_fail++; $display("FAIL add_hold[%0d] done=%b busy=%b got=%b_%h exp=0 0 %b_%h",
                             i, done, busy, cout, sum, exp[W], exp[W-1:0]);
        end
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [W:0] exp;
    int         cyc;
    drive_start(8'h5A, 8'h33, 1'b0, 1'b0);
    tick(); tick();
    a = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got=%b exp=1", busy); end
    wait_done(cyc);
    n_checks++;
    if (done !== 1'b1 || cyc != W - 3) begin
      n_fail++; $display("FAIL ign_latency done=%b cycles=%0d exp=%0d", done, cyc, W - 3);
    end
    exp = sb_q.pop_front();
    n_checks++;
    if ({cout, sum} !== exp || sum !== 8'h8D) begin
      n_fail++; $display("FAIL ign_result got=%b_%h exp=0_8d", cout, sum);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    drive_start(8'hFF, 8'hFF, 1'b1, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state busy=%b done=%b sum=%h cout=%b exp=0 0 00 0", busy, done, sum, cout);
    end
    pulses = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d pulses exp=0", pulses); end
  endtask

  task automatic test_back_to_back;
    logic [W:0] exp;
    int         cyc;
    a = 8'h01; b = 8'h01; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    sb_q.push_back({1'b0, 8'h02});
    start = 1'b1;
    tick();
    for (int p = 0; p < 4; p++) begin
      wait_done(cyc);
      if (p == 3) start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || cyc != ((p == 0) ? W : W + 1)) begin
        n_fail++; $display("FAIL b2b_period[%0d] done=%b cycles=%0d exp=%0d", p, done, cyc, (p == 0) ? W : W + 1);
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy[%0d] got=%b exp=0", p, busy); end
      exp = sb_q.pop_front();
      n_checks++;
      if ({cout, sum} !== exp) begin
        n_fail++; $display("FAIL b2b_result[%0d] got=%b_%h exp=%b_%h", p, cout, sum, exp[W], exp[W-1:0]);
      end
      if (p < 3) sb_q.push_back({1'b0, 8'h02});
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle busy=%b done=%b exp=0 0", busy, done);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [W-1:0] sa[3];
    logic [W-1:0] sbv[3];
    logic [W:0]   exp;
    int           cyc;
    sa[0] = 8'h10; sbv[0] = 8'h01;
    sa[1] = 8'h01; sbv[1] = 8'h02;
    sa[2] = 8'h7F; sbv[2] = 8'h7F;
    for (int i = 0; i < 3; i++) begin
      drive_start(sa[i], sbv[i], 1'b0, 1'b1);
      wait_done(cyc);
      exp = sb_q.pop_front();
      n_checks++;
      if (done !== 1'b1 || {cout, sum} !== exp) begin
        n_fail++; $display("FAIL sub_result[%0d] done=%b got=%b_%h exp=%b_%h", i, done, cout, sum, exp[W], exp[W-1:0]);
      end
      tick();
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
